ray_dispatch_scheduler: RTL
===========================

Name: ray_dispatch_scheduler

Overview:
- Sequences the ray-march pixel pipeline: generates (x,y) pixel coordinates in raster order and issues them into the ray unit.
- Uses credit-based flow control on the number of pixels in flight between issue and retire at the packer.
- Carries per-pixel sof/eol tags through a side FIFO so they reach the packer aligned with shaded pixels.
- Sits between the AXI-Lite control registers (start/continuous bits) and the buffer_manager → getSurfaceVectors → shading → packer chain.

Parameters:
- SCREEN_W, 640, pixels per line
- SCREEN_H, 480, lines per frame
- MAX_INFLIGHT, 16, credit limit and tag FIFO depth; power of two, ≥2
- XW, 10, x coordinate width
- YW, 9, y coordinate width

Ports:
- aclk  in  1  clock (stream clock domain)
- aresetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin a frame when IDLE
- cont_mode  in  1  1 = start next frame automatically after frame end
- issue_valid  out  1  coordinate offered to ray unit
- issue_ready  in  1  ray unit accepts coordinate
- issue_x  out  XW  pixel x
- issue_y  out  YW  pixel y
- retire_valid  in  1  one shaded pixel accepted by packer this cycle
- out_sof  out  1  head-of-FIFO tag: retiring pixel is (0,0)
- out_eol  out  1  head-of-FIFO tag: retiring pixel has x=SCREEN_W-1
- inflight  out  $clog2(MAX_INFLIGHT)+1  pixels issued, not yet retired
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when a frame fully retires
- frame_count  out  16  completed frames; wraps at 65535→0
- err  out  1  sticky: retire_valid with empty FIFO (inflight==0)

Behaviour:
- Reset (async assert, sync deassert inside): state=IDLE, x=0, y=0, inflight=0, FIFO empty, frame_count=0, err=0, frame_done=0. issue_valid, busy, out_sof, out_eol = 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start; start is ignored in RUN and DRAIN.
  - RUN→DRAIN on the cycle the transfer of (SCREEN_W-1, SCREEN_H-1) completes.
  - DRAIN→RUN when inflight reaches 0 and cont_mode=1 (sampled that cycle); →IDLE if cont_mode=0.
- Issue:
  - issue_valid = (state==RUN) && (inflight < MAX_INFLIGHT), combinational.
  - Transfer occurs when issue_valid && issue_ready; only then do x, y advance.
  - issue_x/issue_y hold the current counters and stay stable while valid && !ready.
- Raster counters:
  - x increments; at x==SCREEN_W-1, x→0 and y increments.
  - At (SCREEN_W-1, SCREEN_H-1), x→0 and y→0.
  - Counters reset to 0 on entering RUN from IDLE.
- Tag FIFO:
  - On each transfer, push {sof=(x==0&&y==0), eol=(x==SCREEN_W-1)}.
  - On retire_valid with inflight>0, pop.
  - out_sof/out_eol are the head entry, combinational; both are 0 when empty.
  - Pointers wrap modulo MAX_INFLIGHT.
- inflight arithmetic:
  - +1 on transfer, −1 on valid retire; both in the same cycle → unchanged.
  - Credit check uses the registered inflight, so issue at MAX_INFLIGHT is blocked even if a retire happens that cycle (one-cycle credit return latency).
- Retire when inflight==0:
  - No pop, no decrement, err←1 (sticky until reset).
  - A retire in the same cycle as the first push is still an error.
- Frame completion:
  - frame_done pulses one cycle, and frame_count increments, on the DRAIN cycle where inflight becomes 0.
  - That is the cycle after the final retire is registered, i.e. the cycle state leaves DRAIN.
  - Zero-cycle latency to the next frame's first issue_valid beyond that transition.
- Minimum latency: start at cycle N → issue_valid high at N+1.
- Async reset mid-frame: everything returns to reset values immediately; in-flight tags are discarded.

Test Plan:
- Single frame, ideal pipe. W=4, H=2, MAX_INFLIGHT=4, issue_ready=1, retire two cycles after issue, start pulse, cont_mode=0 → 8 coordinates (0,0)…(3,1) in order; out_sof only on first retire; out_eol on retires 4 and 8; one frame_done; frame_count=1; back to IDLE; busy low.
- Credit stall. retire_valid held 0 → exactly 4 transfers, then issue_valid=0 with inflight=4; one retire → inflight=3, issue_valid=1 next cycle.
- Backpressure. issue_ready=0 for 5 cycles mid-line at (2,0) → issue_x=2, issue_y=0 held stable; no FIFO push; inflight constant.
- Simultaneous issue and retire every cycle at inflight=2 → inflight stays 2; FIFO order preserved.
- Continuous mode. cont_mode=1, one start → frame_done pulses every frame; frame_count increments; next issue (0,0) with sof tag; extra start pulses ignored.
- Error and reset. retire_valid while IDLE → err=1 and persists. aresetn pulsed low mid-frame → all outputs at reset values within the same cycle; err=0.

Source files
------------

// File: rtl/ray_dispatch_scheduler.sv
// ray_dispatch_scheduler
//
// Walks the screen in raster order and offers one (x,y) coordinate per
// transfer to the ray unit. A credit counter limits how many pixels may sit
// between issue and retire at the packer. A side FIFO carries each pixel's
// sof/eol tag so the packer sees tags aligned with the shaded pixel stream.
//
// Handshake: a coordinate moves only on a cycle where issue_valid and
// issue_ready are both high. issue_valid never depends on issue_ready, and
// issue_x/issue_y stay constant while issue_valid is high and issue_ready is
// low. retire_valid is a one-cycle "one pixel accepted by the packer" strobe
// with no back-pressure.
//
// Ports:
//   aclk, aresetn         stream clock, asynchronous active-low reset
//   start, cont_mode      control bits: begin frame / auto-restart
//   issue_valid/_ready    coordinate handshake toward the ray unit
//   issue_x, issue_y      current raster coordinate
//   retire_valid          pixel accepted by the packer
//   out_sof, out_eol      tag of the pixel at the head of the tag FIFO
//   inflight              pixels issued and not yet retired
//   busy                  scheduler is not idle
//   frame_done            one-cycle pulse when a frame has fully retired
//   frame_count           completed frames, wrapping 16-bit count
//   err                   sticky: retire seen with nothing in flight
//   dbg_state             FSM state (0 idle, 1 run, 2 drain)

module ray_dispatch_scheduler #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int MAX_INFLIGHT = 16,
   parameter int XW           = 10,
   parameter int YW           = 9,
   localparam int PW          = $clog2(MAX_INFLIGHT),
   localparam int IW          = PW + 1
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic          start,
   input  logic          cont_mode,
   output logic          issue_valid,
   input  logic          issue_ready,
   output logic [XW-1:0] issue_x,
   output logic [YW-1:0] issue_y,
   input  logic          retire_valid,
   output logic          out_sof,
   output logic          out_eol,
   output logic [IW-1:0] inflight,
   output logic          busy,
   output logic          frame_done,
   output logic [15:0]   frame_count,
   output logic          err,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [XW-1:0] X_LAST  = XW'(SCREEN_W - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(SCREEN_H - 1);
   localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [IW-1:0]   inflight_q, inflight_d;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [1:0]      tag_mem_q [MAX_INFLIGHT];
   logic [15:0]     frame_count_q;
   logic            err_q;

   logic            xfer;
   logic            pop;
   logic            last_pix;
   logic            clear_xy;
   logic            fifo_empty;

   // Credit check is on the registered count: a retire in the same cycle
   // frees the slot only from the next cycle on.
   assign issue_valid = (state_q == S_RUN) && (inflight_q < MAX_CNT);
   assign xfer        = issue_valid && issue_ready;
   assign fifo_empty  = (inflight_q == '0);
   // A retire with nothing registered in flight is an error, even if a push
   // lands in the same cycle; it neither pops nor decrements.
   assign pop         = retire_valid && !fifo_empty;
   assign last_pix    = (x_q == X_LAST) && (y_q == Y_LAST);

   // ---------------- FSM ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      clear_xy   = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               clear_xy = 1'b1;
            end
         end
         S_RUN: begin
            if (xfer && last_pix) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // The frame is complete once the last retire has been registered.
            if (fifo_empty) begin
               frame_done = 1'b1;
               state_d    = cont_mode ? S_RUN : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- raster counters ----------------
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear_xy) begin
         x_d = '0;
         y_d = '0;
      end else if (xfer) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   // ---------------- credit counter ----------------
   always_comb begin
      inflight_d = inflight_q;
      unique case ({xfer, pop})
         2'b10:   inflight_d = inflight_q + IW'(1);
         2'b01:   inflight_d = inflight_q - IW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         x_q           <= '0;
         y_q           <= '0;
         inflight_q    <= '0;
         frame_count_q <= '0;
         err_q         <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         inflight_q    <= inflight_d;
         frame_count_q <= frame_count_q + 16'(frame_done);
         if (retire_valid && fifo_empty) err_q <= 1'b1;
      end
   end

   // ---------------- tag FIFO ----------------
   // The credit counter doubles as the FIFO occupancy, so it never overflows.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < MAX_INFLIGHT; i++) tag_mem_q[i] <= 2'b00;
      end else begin
         if (xfer) begin
            tag_mem_q[wr_ptr_q] <= {(x_q == '0) && (y_q == '0), x_q == X_LAST};
            wr_ptr_q            <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // ---------------- outputs ----------------
   assign out_sof     = !fifo_empty && tag_mem_q[rd_ptr_q][1];
   assign out_eol     = !fifo_empty && tag_mem_q[rd_ptr_q][0];
   assign issue_x     = x_q;
   assign issue_y     = y_q;
   assign inflight    = inflight_q;
   assign busy        = (state_q != S_IDLE);
   assign frame_count = frame_count_q;
   assign err         = err_q;
   assign dbg_state   = state_q;

endmodule
